ysyx_25020047_lsu: RTL and testbench
====================================

Name: ysyx_25020047_lsu

Overview:
- Load/store unit directly upstream of the writeback unit.
- Takes one decoded instruction at a time from the execute stage and performs its data-memory access over a request/grant/response bus.
- Extracts and extends load data, then presents `memdata` together with the pass-through `result`, `snpc` and `inst_type` to writeback via a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 256, max cycles spent in REQ+WAIT before bus-error completion; 0 disables timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  LSU can accept an instruction
- in_inst_type  in  32  one-hot instruction type (codebase encoding)
- in_result  in  32  ALU result; effective address for loads/stores
- in_wdata  in  32  store data (rs2)
- in_snpc  in  32  sequential next PC
- out_valid  out  1  writeback bundle valid
- out_ready  in  1  writeback consumes bundle
- out_inst_type  out  32  registered in_inst_type
- out_result  out  32  registered in_result
- out_snpc  out  32  registered in_snpc
- out_memdata  out  32  extended load data; 0 for non-loads and errors
- out_err  out  1  misaligned access or bus timeout
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  store data shifted to byte lane
- mem_wmask  out  4  byte write strobes
- mem_gnt  in  1  bus accepts request
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  32  read data

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1; out_valid=0; mem_req=0; mem_we=0; mem_wmask=0; mem_addr=0; mem_wdata=0; timeout counter=0; out_* data registers=0; out_err=0.
- Memory types: LW=32'h20, LBU=32'h40, SW=32'h80, SB=32'h100. All other types are non-memory.
- IDLE:
  - in_ready=1.
  - On in_valid, register all inputs.
  - Non-memory type, or misaligned LW/SW (addr[1:0]!=0) -> DONE. Misaligned sets out_err=1 and out_memdata=0, with no bus access.
  - Aligned memory type -> REQ.
- REQ:
  - mem_req=1 with addr/we/wdata/wmask held stable until mem_gnt.
  - Held means held: no address change or deassertion without grant.
  - mem_gnt -> WAIT.
- WAIT:
  - mem_req=0.
  - mem_rvalid -> DONE. For LW, memdata=rdata. For LBU, memdata=zero-extend of byte lane addr[1:0]. For stores, memdata=0 and rvalid is the write ack.
- DONE:
  - out_valid=1; out_* stable.
  - out_ready -> IDLE.
  - No new instruction is accepted in DONE, so there is no bypass from DONE to IDLE acceptance in the same cycle.
- Store lanes:
  - SW: wmask=4'b1111, wdata=in_wdata.
  - SB: wmask=4'b0001<<addr[1:0], wdata=in_wdata[7:0] replicated to all 4 lanes.
  - Loads: wmask=0, we=0.
- Latency (accept edge = cycle 0):
  - Non-memory: out_valid in cycle 1.
  - Memory with immediate gnt and rvalid one cycle after grant: REQ in cycle 1, WAIT in cycle 2, DONE (out_valid) in cycle 3.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When the count equals TIMEOUT_CYCLES (nonzero): go to DONE with out_err=1, memdata=0, mem_req deasserted.
  - mem_rvalid in the same cycle as timeout wins (normal completion).
- mem_rvalid outside WAIT is ignored.
- mem_gnt outside REQ is ignored.
- Reset mid-transaction returns to IDLE immediately. A late rvalid for the abandoned access is ignored.
- Registered outputs only; no combinational path from mem_rdata to out_memdata.

Decomposition:
- Shared package: one-hot inst_type constants (ADDI, JALR, ADD, LUI, LW, LBU, SW, SB, AUIPC, JAL, SUB, SLTI, SLTIU, BEQ, BNE) and LSU state encoding (IDLE, REQ, WAIT, DONE), both shared with the decode and writeback stages.
- One natural sub-module: ysyx_25020047_lsu_align, combinational. It generates store wmask/wdata, extracts load bytes, and detects misalignment.

Test Plan:
- ADD (32'h8), result=0x1234, out_ready=1 -> out_valid one cycle after accept; out_result=0x1234, out_memdata=0, no mem_req.
- LW addr=0x80000004, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x80000004, we=0; out_memdata=0xDEADBEEF at cycle 3.
- LBU addr=0x80000003, rdata=0xAB000000 -> out_memdata=0x000000AB.
- SB addr=0x80000002, wdata=0x1234_56C7, gnt delayed 3 cycles -> mem_req held 4 cycles with wmask=4'b0100, wdata=0xC7C7C7C7; completes on ack.
- SW addr=0x80000001 -> no mem_req, out_err=1, out_valid next cycle.
- LW with TIMEOUT_CYCLES=4, no rvalid -> out_err=1, out_memdata=0 after 4 REQ/WAIT cycles. Separately: rst asserted in WAIT, then rvalid -> state IDLE, out_valid stays 0.

Source files
------------

// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared definitions for the decode, LSU and writeback stages:
// one-hot instruction type encoding and LSU state encoding.
package ysyx_25020047_lsu_pkg;

  localparam logic [31:0] INST_ADDI  = 32'h0000_0001;
  localparam logic [31:0] INST_JALR  = 32'h0000_0002;
  localparam logic [31:0] INST_ADD   = 32'h0000_0008;
  localparam logic [31:0] INST_LUI   = 32'h0000_0010;
  localparam logic [31:0] INST_LW    = 32'h0000_0020;
  localparam logic [31:0] INST_LBU   = 32'h0000_0040;
  localparam logic [31:0] INST_SW    = 32'h0000_0080;
  localparam logic [31:0] INST_SB    = 32'h0000_0100;
  localparam logic [31:0] INST_AUIPC = 32'h0000_0200;
  localparam logic [31:0] INST_JAL   = 32'h0000_0400;
  localparam logic [31:0] INST_SUB   = 32'h0000_0800;
  localparam logic [31:0] INST_SLTI  = 32'h0000_1000;
  localparam logic [31:0] INST_SLTIU = 32'h0000_2000;
  localparam logic [31:0] INST_BEQ   = 32'h0000_4000;
  localparam logic [31:0] INST_BNE   = 32'h0000_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane logic for the LSU: store strobes/data replication, load byte
// extraction and word-access misalignment detection.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic [31:0] st_inst_type,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic        is_mem,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic [31:0] ld_inst_type,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic is_load;

  always_comb begin
    is_load    = (st_inst_type == INST_LW) || (st_inst_type == INST_LBU);
    is_store   = (st_inst_type == INST_SW) || (st_inst_type == INST_SB);
    is_mem     = is_load || is_store;
    misaligned = ((st_inst_type == INST_LW) || (st_inst_type == INST_SW)) && (st_offset != 2'b00);
    wmask      = 4'b0000;
    wdata      = 32'h0;
    if (st_inst_type == INST_SW) begin
      wmask = 4'b1111;
      wdata = st_wdata;
    end else if (st_inst_type == INST_SB) begin
      wmask = 4'b0001 << st_offset;
      wdata = {4{st_wdata[7:0]}};
    end
  end

  // Load extraction works on the captured instruction, so it only ever sees registered type/offset.
  always_comb begin
    ld_data = 32'h0;
    if (ld_inst_type == INST_LW) begin
      ld_data = rdata;
    end else if (ld_inst_type == INST_LBU) begin
      case (ld_offset)
        2'd0:    ld_data = {24'h0, rdata[7:0]};
        2'd1:    ld_data = {24'h0, rdata[15:8]};
        2'd2:    ld_data = {24'h0, rdata[23:16]};
        default: ld_data = {24'h0, rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one instruction, performs its bus access over
// req/gnt/rvalid, and hands the registered bundle to writeback.
module ysyx_25020047_lsu
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst_type,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_snpc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst_type,
  output logic [31:0] out_result,
  output logic [31:0] out_snpc,
  output logic [31:0] out_memdata,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state, state_next;
  logic [31:0] timeout_count;
  logic        timeout_hit;
  logic        is_mem, is_store, misaligned;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata, ld_data;

  ysyx_25020047_lsu_align u_align (
    .st_inst_type (in_inst_type),
    .st_offset    (in_result[1:0]),
    .st_wdata     (in_wdata),
    .is_mem       (is_mem),
    .is_store     (is_store),
    .misaligned   (misaligned),
    .wmask        (st_wmask),
    .wdata        (st_wdata),
    .ld_inst_type (out_inst_type),
    .ld_offset    (out_result[1:0]),
    .rdata        (mem_rdata),
    .ld_data      (ld_data)
  );

  // The current cycle is the last allowed one in REQ/WAIT.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LAST);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_req    = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (is_mem && !misaligned) ? REQ : DONE;
      end
      REQ: begin
        mem_req = 1'b1;
        if (timeout_hit)  state_next = DONE;
        else if (mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rvalid || timeout_hit) state_next = DONE;
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timeout_count <= 32'h0;
      out_inst_type <= 32'h0;
      out_result    <= 32'h0;
      out_snpc      <= 32'h0;
      out_memdata   <= 32'h0;
      out_err       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 4'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_inst_type <= in_inst_type;
            out_result    <= in_result;
            out_snpc      <= in_snpc;
            out_memdata   <= 32'h0;
            out_err       <= misaligned;
            timeout_count <= 32'h0;
            if (is_mem && !misaligned) begin
              mem_addr  <= {in_result[31:2], 2'b00};
              mem_we    <= is_store;
              mem_wdata <= st_wdata;
              mem_wmask <= st_wmask;
            end
          end
        end
        REQ, WAIT: begin
          timeout_count <= timeout_count + 32'd1;
          // A response arriving on the timeout cycle still completes normally.
          if (state == WAIT && mem_rvalid) out_memdata <= ld_data;
          else if (timeout_hit)            out_err     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Self-checking bench for the LSU: directed vector table, randomized
// transactions against a reference model, timeout and reset corner cases.
module tb_ysyx_25020047_lsu;
  import ysyx_25020047_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, mem_gnt, mem_rvalid;
  logic [31:0] in_inst_type, in_result, in_wdata, in_snpc, mem_rdata;
  logic        in_ready, out_valid, out_err, mem_req, mem_we;
  logic [31:0] out_inst_type, out_result, out_snpc, out_memdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        t_in_ready, t_out_valid, t_out_err, t_mem_req, t_mem_we;
  logic [31:0] t_out_inst_type, t_out_result, t_out_snpc, t_out_memdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_type(in_inst_type), .in_result(in_result), .in_wdata(in_wdata), .in_snpc(in_snpc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst_type(out_inst_type),
    .out_result(out_result), .out_snpc(out_snpc), .out_memdata(out_memdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  ysyx_25020047_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_inst_type(in_inst_type), .in_result(in_result), .in_wdata(in_wdata), .in_snpc(in_snpc),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_inst_type(t_out_inst_type),
    .out_result(t_out_result), .out_snpc(t_out_snpc), .out_memdata(t_out_memdata), .out_err(t_out_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wmask(t_mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] inst_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] snpc;
    logic [31:0] rdata;
    int          gnt_delay;
    int          rv_delay;
    int          ready_delay;
    bit          noise;
    bit          exp_bus;
    bit          exp_we;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_memdata;
    bit          exp_err;
  } vec_t;

  vec_t table_v[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reference model: derives bus and writeback expectations from the instruction alone.
  function automatic vec_t predict(input vec_t v);
    vec_t        r = v;
    int unsigned off = v.addr % 4;
    bit lw  = (v.inst_type == INST_LW);
    bit lbu = (v.inst_type == INST_LBU);
    bit sw  = (v.inst_type == INST_SW);
    bit sb  = (v.inst_type == INST_SB);
    r.exp_err     = (lw || sw) && off != 0;
    r.exp_bus     = (lw || lbu || sw || sb) && !r.exp_err;
    r.exp_we      = sw || sb;
    r.exp_wmask   = sw ? 4'hF : (sb ? 4'(1 << off) : 4'h0);
    r.exp_wdata   = sw ? v.wdata : (sb ? (v.wdata % 256) * 32'h0101_0101 : 32'h0);
    r.exp_memdata = r.exp_err ? 32'h0 : (lw ? v.rdata : (lbu ? (v.rdata >> (8 * off)) % 256 : 32'h0));
    return r;
  endfunction

  task automatic applyStimulus(input int id, input vec_t v);
    int          req_cycles = 0;
    int          wait_cycles = 0;
    int          lat = 0;
    int          exp_lat;
    bit          saw_req = 0;
    bit          done_seen = 0;
    logic [31:0] word_addr = v.addr - (v.addr % 4);
    string       tag = $sformatf("v%0d", id);

    in_inst_type = v.inst_type; in_result = v.addr; in_wdata = v.wdata; in_snpc = v.snpc;
    in_valid = 1'b1;
    checkOutput({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 64 && !done_seen; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (out_valid) begin
        done_seen = 1;
        lat = k;
      end else begin
        if (mem_req) begin
          req_cycles++;
          saw_req = 1;
          checkOutput({tag, ".mem_addr"}, mem_addr, word_addr);
          checkOutput({tag, ".mem_we"}, mem_we, v.exp_we);
          checkOutput({tag, ".mem_wmask"}, mem_wmask, v.exp_wmask);
          checkOutput({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
          if (req_cycles > v.gnt_delay) mem_gnt = 1'b1;
          if (v.noise) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ~v.rdata;
          end
        end else if (saw_req) begin
          wait_cycles++;
          if (wait_cycles > v.rv_delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
          end
        end
        step();
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_lat = v.exp_bus ? 1 + (v.gnt_delay + 1) + (v.rv_delay + 1) : 1;
    checkOutput({tag, ".done_seen"}, done_seen, 1);
    checkOutput({tag, ".latency"}, lat, exp_lat);
    checkOutput({tag, ".req_cycles"}, req_cycles, v.exp_bus ? v.gnt_delay + 1 : 0);
    checkOutput({tag, ".out_inst_type"}, out_inst_type, v.inst_type);
    checkOutput({tag, ".out_result"}, out_result, v.addr);
    checkOutput({tag, ".out_snpc"}, out_snpc, v.snpc);
    checkOutput({tag, ".out_memdata"}, out_memdata, v.exp_memdata);
    checkOutput({tag, ".out_err"}, out_err, v.exp_err);
    if (v.ready_delay > 0) begin
      for (int r = 0; r < v.ready_delay; r++) begin
        in_valid = 1'b1; in_inst_type = INST_ADD; in_result = $urandom;
        step();
      end
      in_valid = 1'b0;
      checkOutput({tag, ".hold_valid"}, out_valid, 1);
      checkOutput({tag, ".hold_result"}, out_result, v.addr);
      checkOutput({tag, ".hold_memdata"}, out_memdata, v.exp_memdata);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, ".released"}, out_valid, 0);
    checkOutput({tag, ".in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] types[8] = '{INST_ADD, INST_ADDI, INST_BNE, INST_LW, INST_LBU, INST_SW, INST_SB, INST_LW};
    vec_t        v;
    int          lat;

    // inst_type, addr, wdata, snpc, rdata, gnt, rv, ready, noise, bus, we, wmask, wdata, memdata, err
    table_v[0]  = '{INST_ADD, 32'h0000_1234, 32'h0, 32'h8000_0008, 32'h0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0};
    table_v[1]  = '{INST_LW, 32'h8000_0004, 32'h0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'hDEAD_BEEF, 0};
    table_v[2]  = '{INST_LBU, 32'h8000_0003, 32'h0, 32'h8000_0014, 32'hAB00_0000, 0, 0, 1, 0, 1, 0, 4'h0, 32'h0, 32'h0000_00AB, 0};
    table_v[3]  = '{INST_SB, 32'h8000_0002, 32'h1234_56C7, 32'h8000_0018, 32'h0, 3, 0, 0, 0, 1, 1, 4'b0100, 32'hC7C7_C7C7, 32'h0, 0};
    table_v[4]  = '{INST_SW, 32'h8000_0001, 32'h5566_7788, 32'h8000_001C, 32'h0, 0, 0, 0, 0, 0, 1, 4'hF, 32'h5566_7788, 32'h0, 1};
    table_v[5]  = '{INST_SW, 32'h8000_0010, 32'hCAFE_F00D, 32'h8000_0020, 32'h7777_7777, 1, 2, 3, 1, 1, 1, 4'hF, 32'hCAFE_F00D, 32'h0, 0};
    table_v[6]  = '{INST_LW, 32'h8000_0002, 32'h0, 32'h8000_0024, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1};
    table_v[7]  = '{INST_LBU, 32'h8000_0100, 32'h0, 32'h8000_0028, 32'h1234_56F0, 2, 1, 0, 1, 1, 0, 4'h0, 32'h0, 32'h0000_00F0, 0};
    table_v[8]  = '{INST_SB, 32'h8000_000B, 32'h0000_00A5, 32'h8000_002C, 32'h0, 0, 1, 0, 0, 1, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0};
    table_v[9]  = '{INST_BEQ, 32'hFFFF_FFFF, 32'h0, 32'h8000_0030, 32'h0, 0, 0, 2, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0};
    table_v[10] = '{INST_LBU, 32'h8000_0001, 32'h0, 32'h8000_0034, 32'h0000_C300, 0, 3, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0000_00C3, 0};

    in_inst_type = 32'h0; in_result = 32'h0; in_wdata = 32'h0; in_snpc = 32'h0; mem_rdata = 32'h0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    checkOutput("rst.in_ready", in_ready, 1);
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.mem_req", mem_req, 0);
    checkOutput("rst.mem_we", mem_we, 0);
    checkOutput("rst.mem_wmask", mem_wmask, 0);
    checkOutput("rst.mem_addr", mem_addr, 0);
    checkOutput("rst.mem_wdata", mem_wdata, 0);
    checkOutput("rst.out_result", out_result, 0);
    checkOutput("rst.out_memdata", out_memdata, 0);
    checkOutput("rst.out_err", out_err, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) applyStimulus(i, table_v[i]);

    for (int i = 0; i < 40; i++) begin
      v.inst_type   = types[$urandom_range(0, 7)];
      v.addr        = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | ($urandom_range(0, 1) ? 32'd0 : 32'($urandom_range(1, 3)));
      v.wdata       = $urandom;
      v.snpc        = $urandom;
      v.rdata       = $urandom;
      v.gnt_delay   = $urandom_range(0, 3);
      v.rv_delay    = $urandom_range(0, 3);
      v.ready_delay = $urandom_range(0, 2);
      v.noise       = 1'($urandom_range(0, 1));
      applyStimulus(100 + i, predict(v));
    end

    // Timeout with no response: 4 cycles in REQ/WAIT, then error completion.
    do_reset();
    in_inst_type = INST_LW; in_result = 32'h8000_0100; in_snpc = 32'h8000_0200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (t_out_valid) lat = k;
      else begin
        if (t_mem_req) mem_gnt = 1'b1;
        step();
      end
    end
    mem_gnt = 1'b0;
    checkOutput("to.latency", lat, 5);
    checkOutput("to.out_err", t_out_err, 1);
    checkOutput("to.out_memdata", t_out_memdata, 0);
    checkOutput("to.mem_req", t_mem_req, 0);

    // Response on the timeout cycle completes normally.
    do_reset();
    in_inst_type = INST_LW; in_result = 32'h8000_0104; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("to_rv.mem_req", t_mem_req, 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    step();
    checkOutput("to_rv.not_done", t_out_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_1234;
    step();
    mem_rvalid = 1'b0;
    checkOutput("to_rv.out_valid", t_out_valid, 1);
    checkOutput("to_rv.out_err", t_out_err, 0);
    checkOutput("to_rv.out_memdata", t_out_memdata, 32'h5A5A_1234);

    // Reset while waiting for a response; the late response must be ignored.
    do_reset();
    in_inst_type = INST_LW; in_result = 32'h8000_0200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("rstw.mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("rstw.in_wait", mem_req, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("rstw.out_valid", out_valid, 0);
      checkOutput("rstw.in_ready", in_ready, 1);
    end
    mem_rvalid = 1'b0;
    checkOutput("rstw.out_memdata", out_memdata, 0);
    checkOutput("rstw.mem_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
